bp_cfg_init_sequencer: RTL and testbench
========================================

// Module: bp_cfg_init_sequencer
// PURPOSE
//   Boot-time configuration master for the core array. On start, walks every core tile and issues an
//   ordered series of single-beat config-bus writes: freeze all, set core id, set CCE mode, unfreeze all.
//   It is one requester on the config bus, with one write outstanding at a time. The write count scales
//   with the selected proc config (cc_x_dim*cc_y_dim cores). It sits between the host/boot ROM start
//   strobe and the per-tile cfg bus.
// PARAMETERS
//   num_core_p        1      number of cores to configure (cc_x_dim*cc_y_dim); >=1
//   core_id_width_p   4      width of cfg_core_o; must hold num_core_p-1
//   cfg_addr_width_p  16     config register address width
//   cfg_data_width_p  64     config write data width
//   cce_mode_p        0      value written to CCE-mode register (0=uncached,1=normal)
//   timeout_p         1024   cycles to wait for an ack before aborting; >=2
//   Fixed addrs: FREEZE=16'h0002, CORE_ID=16'h0004, CCE_MODE=16'h0008 (zero-extended to cfg_addr_width_p)
// PORTS
//   clk_i        in   1                 clock
//   reset_i      in   1                 synchronous, active-high reset
//   start_i      in   1                 level; sampled only in IDLE/DONE
//   busy_o       out  1                 sequence in progress
//   done_o       out  1                 sticky; sequence finished (ok or error) until next start
//   error_o      out  1                 sticky; ack timeout occurred
//   cfg_v_o      out  1                 write valid
//   cfg_ready_i  in   1                 bus accepts write when cfg_v_o & cfg_ready_i
//   cfg_core_o   out  core_id_width_p   target core
//   cfg_addr_o   out  cfg_addr_width_p  register address
//   cfg_data_o   out  cfg_data_width_p  write data
//   cfg_ack_i    in   1                 write-complete response from target
// BEHAVIOUR
//   Reset: state=IDLE; busy_o=done_o=error_o=cfg_v_o=0; core counter=0; timeout counter=0; payload=0.
//   States: IDLE, SEND, WAIT, DONE. Phase reg: FRZ -> CID -> MODE -> UNFRZ.
//   IDLE/DONE: start_i=1 -> SEND next cycle, phase=FRZ, core=0, done_o=error_o cleared, busy_o=1.
//   SEND: cfg_v_o=1; payload from phase/core: FRZ {FREEZE,1}; CID {CORE_ID,core}; MODE {CCE_MODE,
//     cce_mode_p}; UNFRZ {FREEZE,0}. Payload and cfg_v_o held stable until handshake. Handshake -> WAIT.
//   WAIT: cfg_v_o=0; timeout counter increments each cycle. cfg_ack_i=1 -> advance, counter cleared:
//     FRZ: core++ until num_core_p-1, then core=0, phase=CID.
//     CID -> MODE (same core).
//     MODE: core++ and back to CID, or core=0, phase=UNFRZ after last core.
//     UNFRZ: core++, or DONE after last.
//     Not done -> SEND.
//   Timeout: counter reaches timeout_p-1 with no ack -> DONE, error_o=1; no further writes.
//   DONE: busy_o=0, done_o=1, cfg_v_o=0.
//   Order: all cores frozen before any CID write; no unfreeze before every MODE write is acked.
//   Writes total 4*num_core_p. Zero-wait bus (ready=1, ack one cycle after handshake): 2 cycles/write.
//   start_i while busy_o=1 ignored. cfg_ack_i outside WAIT ignored (no state change).
//   Ack same cycle as timeout expiry: ack wins (treated as success).
//   reset_i mid-sequence: back to IDLE next cycle; cfg_v_o drops; partial config not undone.
//   Core counter is core_id_width_p bits; no wrap beyond num_core_p-1.
// TESTING
//   num_core_p=2, ready=1, ack 1 cycle after handshake, start at cycle 0 -> 8 writes
//     (c0,2,1)(c1,2,1)(c0,4,0)(c0,8,0)(c1,4,1)(c1,8,0)(c0,2,0)(c1,2,0); done_o=1 at cycle 17.
//   cfg_ready_i low 3 cycles during CID write -> cfg_v_o and core/addr/data unchanged for 4 cycles; order intact.
//   timeout_p=16, no ack after first write -> error_o=done_o=1 exactly 16 cycles later; cfg_v_o=0 thereafter.
//   start_i pulse during SEND, spurious cfg_ack_i during SEND -> sequence and write count unaffected.
//   reset_i asserted during MODE phase -> next cycle all outputs 0, IDLE; restart yields full 8-write sequence.
//   num_core_p=1, cce_mode_p=1 -> 4 writes, MODE data=1; done_o stays high until next start_i.

Source files
------------

// File: rtl/bp_cfg_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_init_sequencer
// Brief    : Boot-time configuration master. Walks every core tile and issues
//            freeze-all, set core id, set CCE mode, unfreeze-all writes on the
//            config bus. Only one write is outstanding at a time, and each
//            write must be acked before the next one is sent.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cfg_init_sequencer #(
  parameter int num_core_p       = 1,
  parameter int core_id_width_p  = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int cce_mode_p       = 0,
  parameter int timeout_p        = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_i
);

  localparam int cnt_width_lp = $clog2(timeout_p);

  localparam logic [1:0] state_idle_lc = 2'd0;
  localparam logic [1:0] state_send_lc = 2'd1;
  localparam logic [1:0] state_wait_lc = 2'd2;
  localparam logic [1:0] state_done_lc = 2'd3;

  localparam logic [1:0] phase_frz_lc   = 2'd0;
  localparam logic [1:0] phase_cid_lc   = 2'd1;
  localparam logic [1:0] phase_mode_lc  = 2'd2;
  localparam logic [1:0] phase_unfrz_lc = 2'd3;

  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lc   = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] addr_core_id_lc  = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_mode_lc = cfg_addr_width_p'(16'h0008);

  localparam logic [core_id_width_p-1:0] last_core_lc    = core_id_width_p'(num_core_p - 1);
  localparam logic [cnt_width_lp-1:0]    timeout_last_lc = cnt_width_lp'(timeout_p - 1);

  logic [1:0]                 state_q, state_d;
  logic [1:0]                 phase_q, phase_d;
  logic [core_id_width_p-1:0] core_q,  core_d;
  logic [cnt_width_lp-1:0]    cnt_q,   cnt_d;
  logic                       error_q, error_d;
  logic                       last_core;

  assign last_core = (core_q == last_core_lc);

  // Next-state logic: sequence walk, ack handling and ack timeout.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    core_d  = core_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      state_idle_lc, state_done_lc: begin
        if (start_i) begin
          state_d = state_send_lc;
          phase_d = phase_frz_lc;
          core_d  = '0;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      state_send_lc: begin
        // Payload is a function of phase/core, which stay frozen here, so it
        // remains stable until the bus takes it.
        if (cfg_ready_i) begin
          state_d = state_wait_lc;
          cnt_d   = '0;
        end
      end
      state_wait_lc: begin
        // An ack in the expiry cycle still counts as success.
        if (cfg_ack_i) begin
          cnt_d   = '0;
          state_d = state_send_lc;
          case (phase_q)
            phase_frz_lc: begin
              if (last_core) begin
                core_d  = '0;
                phase_d = phase_cid_lc;
              end else begin
                core_d = core_q + 1'b1;
              end
            end
            phase_cid_lc: begin
              phase_d = phase_mode_lc;
            end
            phase_mode_lc: begin
              if (last_core) begin
                core_d  = '0;
                phase_d = phase_unfrz_lc;
              end else begin
                core_d  = core_q + 1'b1;
                phase_d = phase_cid_lc;
              end
            end
            phase_unfrz_lc: begin
              if (last_core) begin
                core_d  = '0;
                state_d = state_done_lc;
              end else begin
                core_d = core_q + 1'b1;
              end
            end
          endcase
        end else if (cnt_q == timeout_last_lc) begin
          state_d = state_done_lc;
          error_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = state_idle_lc;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= state_idle_lc;
      phase_q <= phase_frz_lc;
      core_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      core_q  <= core_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Write payload, driven only while a write is being offered.
  always_comb begin
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (state_q == state_send_lc) begin
      cfg_core_o = core_q;
      case (phase_q)
        phase_frz_lc: begin
          cfg_addr_o = addr_freeze_lc;
          cfg_data_o = cfg_data_width_p'(1);
        end
        phase_cid_lc: begin
          cfg_addr_o = addr_core_id_lc;
          cfg_data_o = cfg_data_width_p'(core_q);
        end
        phase_mode_lc: begin
          cfg_addr_o = addr_cce_mode_lc;
          cfg_data_o = cfg_data_width_p'(cce_mode_p);
        end
        phase_unfrz_lc: begin
          cfg_addr_o = addr_freeze_lc;
          cfg_data_o = '0;
        end
      endcase
    end
  end

  assign cfg_v_o = (state_q == state_send_lc);
  assign busy_o  = (state_q == state_send_lc) || (state_q == state_wait_lc);
  assign done_o  = (state_q == state_done_lc);
  assign error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cfg_init_sequencer
// Brief    : Directed self-checking bench for bp_cfg_init_sequencer. DUT A is
//            a 2-core / short-timeout build, DUT B a 1-core build with
//            CCE mode 1. A select bit routes the shared stimulus to one DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cfg_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ready, ack, sel;

  logic        busy_a, done_a, error_a, v_a;
  logic [3:0]  core_a;
  logic [15:0] addr_a;
  logic [63:0] data_a;
  logic        busy_b, done_b, error_b, v_b;
  logic [3:0]  core_b;
  logic [15:0] addr_b;
  logic [63:0] data_b;

  logic        start_a, start_b, ack_a, ack_b;
  assign start_a = sel ? 1'b0 : start;
  assign start_b = sel ? start : 1'b0;
  assign ack_a   = sel ? 1'b0 : ack;
  assign ack_b   = sel ? ack : 1'b0;

  logic        busy_s, done_s, error_s, v_s;
  logic [3:0]  core_s;
  logic [15:0] addr_s;
  logic [63:0] data_s;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;
  assign error_s = sel ? error_b : error_a;
  assign v_s     = sel ? v_b     : v_a;
  assign core_s  = sel ? core_b  : core_a;
  assign addr_s  = sel ? addr_b  : addr_a;
  assign data_s  = sel ? data_b  : data_a;

  bp_cfg_init_sequencer #(
    .num_core_p(2), .core_id_width_p(4), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .cce_mode_p(0), .timeout_p(16)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start_a), .busy_o(busy_a),
    .done_o(done_a), .error_o(error_a), .cfg_v_o(v_a), .cfg_ready_i(ready),
    .cfg_core_o(core_a), .cfg_addr_o(addr_a), .cfg_data_o(data_a), .cfg_ack_i(ack_a)
  );

  bp_cfg_init_sequencer #(
    .num_core_p(1), .core_id_width_p(4), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .cce_mode_p(1), .timeout_p(1024)
  ) u_dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start_b), .busy_o(busy_b),
    .done_o(done_b), .error_o(error_b), .cfg_v_o(v_b), .cfg_ready_i(ready),
    .cfg_core_o(core_b), .cfg_addr_o(addr_b), .cfg_data_o(data_b), .cfg_ack_i(ack_b)
  );

  int checks   = 0;
  int failures = 0;

  int e2_core[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
  int e2_addr[8] = '{2, 2, 4, 8, 4, 8, 2, 2};
  int e2_data[8] = '{1, 1, 0, 0, 1, 0, 0, 0};
  int e1_addr[4] = '{2, 4, 8, 2};
  int e1_data[4] = '{1, 0, 1, 0};

  logic [3:0]  wcore[16];
  logic [15:0] waddr[16];
  logic [63:0] wdata[16];
  int nw, done_cyc, stall_vcyc;
  bit stall_diff;

  // Bus responder: cycle 0 is the start cycle; ack one cycle after handshake.
  task automatic run_seq(input int max_cyc, input int stall_idx, input int stall_len,
                         input bit spur, input int noack_idx);
    bit ack_next;
    int stall_cnt;
    logic [3:0]  s_core;
    logic [15:0] s_addr;
    logic [63:0] s_data;
    ack_next = 1'b0; stall_cnt = 0; s_core = '0; s_addr = '0; s_data = '0;
    nw = 0; done_cyc = -1; stall_vcyc = 0; stall_diff = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc > 0 && done_s) begin
        done_cyc = cyc;
        break;
      end
      start    = (cyc == 0) || (spur && cyc == 3);
      ack      = ack_next || (spur && cyc == 3);
      ack_next = 1'b0;
      ready    = 1'b1;
      if (v_s && nw == stall_idx) begin
        if (stall_vcyc == 0) begin
          s_core = core_s; s_addr = addr_s; s_data = data_s;
        end else if (core_s !== s_core || addr_s !== s_addr || data_s !== s_data) begin
          stall_diff = 1'b1;
        end
        stall_vcyc++;
        if (stall_cnt < stall_len) begin
          ready = 1'b0;
          stall_cnt++;
        end
      end
      if (v_s && ready) begin
        if (nw < 16) begin
          wcore[nw] = core_s; waddr[nw] = addr_s; wdata[nw] = data_s;
        end
        ack_next = (nw < noack_idx);
        nw++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; ack = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, error_a, v_a} !== 4'b0 || core_a !== 4'd0 || addr_a !== 16'd0 || data_a !== 64'd0) begin
      failures++;
      $display("FAIL reset_a: got busy=%b done=%b err=%b v=%b core=%0d addr=%h data=%h, expected all 0",
               busy_a, done_a, error_a, v_a, core_a, addr_a, data_a);
    end
    checks++;
    if ({busy_b, done_b, error_b, v_b} !== 4'b0 || core_b !== 4'd0 || addr_b !== 16'd0 || data_b !== 64'd0) begin
      failures++;
      $display("FAIL reset_b: got busy=%b done=%b err=%b v=%b core=%0d addr=%h data=%h, expected all 0",
               busy_b, done_b, error_b, v_b, core_b, addr_b, data_b);
    end
  endtask

  task automatic test_two_core_sequence(input string name, input int stall_idx,
                                       input int stall_len, input bit spur, input int exp_done);
    sel = 1'b0;
    run_seq(60, stall_idx, stall_len, spur, 99);
    checks++;
    if (nw !== 8) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, expected 8", name, nw);
    end
    for (int i = 0; i < 8 && i < nw; i++) begin
      checks++;
      if (wcore[i] !== 4'(e2_core[i]) || waddr[i] !== 16'(e2_addr[i]) || wdata[i] !== 64'(e2_data[i])) begin
        failures++;
        $display("FAIL %s_write%0d: got (c%0d,%0h,%0h), expected (c%0d,%0h,%0h)", name, i,
                 wcore[i], waddr[i], wdata[i], e2_core[i], e2_addr[i], e2_data[i]);
      end
    end
    checks++;
    if (done_cyc !== exp_done || error_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: got done_cycle=%0d err=%b busy=%b, expected done_cycle=%0d err=0 busy=0",
               name, done_cyc, error_s, busy_s, exp_done);
    end
  endtask

  task automatic test_basic();
    test_two_core_sequence("basic", -1, 0, 1'b0, 17);
  endtask

  task automatic test_ready_stall();
    test_two_core_sequence("stall", 2, 3, 1'b0, 20);
    checks++;
    if (stall_vcyc !== 4 || stall_diff !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: got %0d valid cycles changed=%b, expected 4 valid cycles changed=0",
               stall_vcyc, stall_diff);
    end
  endtask

  task automatic test_spurious();
    test_two_core_sequence("spurious", -1, 0, 1'b1, 17);
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    run_seq(60, -1, 0, 1'b0, 0);
    checks++;
    if (nw !== 1 || done_cyc !== 18 || error_s !== 1'b1 || done_s !== 1'b1) begin
      failures++;
      $display("FAIL timeout: got writes=%0d done_cycle=%0d err=%b done=%b, expected 1, 18, 1, 1",
               nw, done_cyc, error_s, done_s);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (v_s !== 1'b0 || error_s !== 1'b1 || done_s !== 1'b1) begin
        failures++;
        $display("FAIL timeout_hold%0d: got v=%b err=%b done=%b, expected v=0 err=1 done=1",
                 i, v_s, error_s, done_s);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    run_seq(8, -1, 0, 1'b0, 99);
    checks++;
    if (nw !== 4 || busy_s !== 1'b1 || v_s !== 1'b0 || waddr[3] !== 16'h0008) begin
      failures++;
      $display("FAIL mid_state: got writes=%0d busy=%b v=%b last_addr=%h, expected 4, 1, 0, 0008",
               nw, busy_s, v_s, waddr[3]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, error_a, v_a} !== 4'b0 || core_a !== 4'd0 || addr_a !== 16'd0 || data_a !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b done=%b err=%b v=%b core=%0d addr=%h data=%h, expected all 0",
               busy_a, done_a, error_a, v_a, core_a, addr_a, data_a);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    test_two_core_sequence("restart", -1, 0, 1'b0, 17);
  endtask

  task automatic test_single_core();
    sel = 1'b1;
    run_seq(40, -1, 0, 1'b0, 99);
    checks++;
    if (nw !== 4 || done_cyc !== 9) begin
      failures++;
      $display("FAIL single_count: got writes=%0d done_cycle=%0d, expected 4 and 9", nw, done_cyc);
    end
    for (int i = 0; i < 4 && i < nw; i++) begin
      checks++;
      if (wcore[i] !== 4'd0 || waddr[i] !== 16'(e1_addr[i]) || wdata[i] !== 64'(e1_data[i])) begin
        failures++;
        $display("FAIL single_write%0d: got (c%0d,%0h,%0h), expected (c0,%0h,%0h)", i,
                 wcore[i], waddr[i], wdata[i], e1_addr[i], e1_data[i]);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_s !== 1'b1 || busy_s !== 1'b0 || error_s !== 1'b0) begin
      failures++;
      $display("FAIL single_sticky: got done=%b busy=%b err=%b, expected 1 0 0", done_s, busy_s, error_s);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b1 || v_s !== 1'b1) begin
      failures++;
      $display("FAIL single_restart: got done=%b busy=%b v=%b, expected 0 1 1", done_s, busy_s, v_s);
    end
    run_seq(40, -1, 0, 1'b0, 99);
    checks++;
    if (nw !== 4 || done_s !== 1'b1) begin
      failures++;
      $display("FAIL single_rerun: got writes=%0d done=%b, expected 4 and 1", nw, done_s);
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; ack = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_ready_stall();
    test_spurious();
    test_timeout();
    test_basic();
    test_reset_mid();
    test_single_core();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
